reaction_timer_core: RTL and testbench

// - Upstream stage of the 4-digit 7-segment multiplexer. It implements a reaction-time game:

---
 rtl/rt_pkg.sv | 42 ++++
 rtl/btn_debounce.sv | 47 ++++
 rtl/reaction_timer_core.sv | 96 +++++++++
 tb/tb_reaction_timer_core.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rt_pkg.sv
// rt_pkg: shared state encoding, LFSR taps and BCD helpers for the reaction timer
// Contents:
//   state_t        FSM encoding IDLE/ARM/GO/DONE
//   LFSR_TAP_MASK  feedback taps of the 16-bit Fibonacci LFSR (bits 15,14,12,3)
//   BCD_MAX        saturation value of the 4-digit BCD result
//   lfsr_next      one shift-left step of the LFSR
//   bcd_inc        4-digit BCD increment with ripple carry
package rt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        GO   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [15:0] LFSR_TAP_MASK = 16'hD008;
    localparam logic [15:0] BCD_MAX       = 16'h9999;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], ^(l & LFSR_TAP_MASK)};
    endfunction

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (v[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronise and debounce an active-low push-button into a single press pulse
// Ports:
//   clk    in   system clock
//   rst_n  in   synchronous reset, active-low; debounced level returns to released
//   btn_n  in   raw asynchronous, bouncy button, active-low
//   press  out  1-cycle pulse on each debounced press (release produces nothing)
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 270_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic [1:0]    sync;
    logic          level;
    logic [CW-1:0] cnt;
    logic          settle;

    // cnt counts consecutive synchronised samples that disagree with the debounced level;
    // the level flips on the DEBOUNCE_CYC-th such sample
    assign settle = (sync[1] != level) && (cnt == CW'(DEBOUNCE_CYC - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync  <= 2'b11;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], btn_n};
            press <= settle && !sync[1];
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (settle) begin
                cnt   <= '0;
                level <= sync[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/reaction_timer_core.sv
// reaction_timer_core: reaction-time game producing a 4-digit BCD millisecond result
// Ports:
//   clk           in   system clock, all logic on posedge
//   rst_n         in   synchronous reset, active-low
//   btn_n         in   raw push-button, active-low, asynchronous, bouncy
//   go_led        out  high while in GO
//   digits        out  BCD result, [3:0]=ones .. [15:12]=thousands
//   result_valid  out  high in DONE
//   foul          out  last attempt was an early press
//   timeout       out  last attempt saturated at 9999 ms
module reaction_timer_core
    import rt_pkg::*;
#(
    parameter int          CLK_HZ       = 27_000_000,
    parameter int          DEBOUNCE_CYC = 270_000,
    parameter int          MIN_DELAY_MS = 1000,
    parameter logic [15:0] LFSR_SEED    = 16'h1234
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_n,
    output logic        go_led,
    output logic [15:0] digits,
    output logic        result_valid,
    output logic        foul,
    output logic        timeout
);

    localparam int MS_CYC = CLK_HZ / 1000;
    localparam int PW     = $clog2(MS_CYC + 1);
    localparam int DW     = $clog2(MIN_DELAY_MS + 2048);

    state_t          state;
    state_t          state_nx;
    logic [15:0]     lfsr;
    logic [PW-1:0]   presc;
    logic [DW-1:0]   delay;
    logic            press;
    logic            tick;
    logic            arm_entry;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (btn_n),
        .press (press)
    );

    assign tick         = presc == PW'(MS_CYC - 1);
    assign arm_entry    = (state_nx == ARM) && (state != ARM);
    assign go_led       = state == GO;
    assign result_valid = state == DONE;

    // press has priority over any tick in the same cycle, both in ARM (foul) and in GO (freeze)
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (press) state_nx = ARM;
            ARM:     if (press) state_nx = DONE;
                     else if (tick && delay == DW'(1)) state_nx = GO;
            GO:      if (press || (tick && digits == BCD_MAX)) state_nx = DONE;
            DONE:    if (press) state_nx = ARM;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            lfsr    <= LFSR_SEED;
            presc   <= '0;
            delay   <= '0;
            digits  <= '0;
            foul    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state <= state_nx;
            lfsr  <= lfsr_next(lfsr);
            // restarting on every state change makes the first tick land exactly MS_CYC cycles in
            presc <= (state_nx != state || tick) ? '0 : presc + 1'b1;
            if (arm_entry) begin
                delay   <= DW'(MIN_DELAY_MS) + DW'(lfsr[10:0]);
                digits  <= '0;
                foul    <= 1'b0;
                timeout <= 1'b0;
            end else if (state == ARM) begin
                if (press) foul <= 1'b1;
                else if (tick) delay <= delay - 1'b1;
            end else if (state == GO && !press && tick) begin
                if (digits == BCD_MAX) timeout <= 1'b1;
                else digits <= bcd_inc(digits);
            end
        end
    end

endmodule

// File: tb/tb_reaction_timer_core.sv
// tb_reaction_timer_core: scoreboard bench; dut runs at 10 cycles/ms, dut_t at 1 cycle/ms for timeout
module tb_reaction_timer_core;

    localparam int MS        = 10;
    localparam int DEB       = 4;
    localparam int PRESS_LAT = 2 + DEB;
    localparam int HOLD      = 12;

    typedef struct packed {
        logic [15:0] d;
        logic        f;
        logic        t;
    } res_t;

    bit          clk = 0;
    logic        rst_n = 0;
    logic        btn_n = 1;
    logic        btn2_n = 1;
    logic        go_led, result_valid, foul, timeout;
    logic        go2, rv2, foul2, to2;
    logic [15:0] digits, dig2;

    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    int          bcd_bad = 0;
    logic [15:0] m_lfsr = 16'h1234;
    bit          rst_done = 0;
    bit          t_done = 0;
    bit          go_p = 0, rv_p = 0, go2_p = 0, rv2_p = 0;

    int   press_q[$];
    int   goq[$];
    int   goq2[$];
    res_t dq[$];
    res_t dq2[$];

    reaction_timer_core #(.CLK_HZ(10_000), .DEBOUNCE_CYC(DEB)) dut (
        .clk(clk), .rst_n(rst_n), .btn_n(btn_n), .go_led(go_led), .digits(digits),
        .result_valid(result_valid), .foul(foul), .timeout(timeout)
    );

    reaction_timer_core #(.CLK_HZ(1_000), .DEBOUNCE_CYC(DEB)) dut_t (
        .clk(clk), .rst_n(rst_n), .btn_n(btn2_n), .go_led(go2), .digits(dig2),
        .result_valid(rv2), .foul(foul2), .timeout(to2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        m_lfsr <= !rst_n ? 16'h1234 : {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[14] ^ m_lfsr[12] ^ m_lfsr[3]};
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] ahead(input logic [15:0] l, input int n);
        logic [15:0] r;
        r = l;
        for (int i = 0; i < n; i++) r = {r[14:0], r[15] ^ r[14] ^ r[12] ^ r[3]};
        return r;
    endfunction

    function automatic bit non_bcd(input logic [15:0] v);
        non_bcd = 0;
        for (int i = 0; i < 4; i++) if (v[i*4 +: 4] > 4'd9) non_bcd = 1;
    endfunction

    // idle until the LFSR value seen lat cycles from now gives a short random delay
    task automatic wait_good(input int lat, output logic [15:0] v);
        int i;
        i = 0;
        v = ahead(m_lfsr, lat);
        while (v[10:0] >= 11'd50 && i < 4000) begin
            @(negedge clk);
            i++;
            v = ahead(m_lfsr, lat);
        end
    endtask

    task automatic drive(input bit which, input logic v);
        if (which) btn2_n = v;
        else btn_n = v;
    endtask

    task automatic press_at(input bit which, input int t);
        while (cyc < t - PRESS_LAT) @(negedge clk);
        drive(which, 1'b0);
        if (!which) press_q.push_back(cyc + PRESS_LAT);
        repeat (HOLD) @(negedge clk);
        drive(which, 1'b1);
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic arm(input bit which, output int e, output int d);
        logic [15:0] v;
        wait_good(PRESS_LAT, v);
        drive(which, 1'b0);
        if (!which) press_q.push_back(cyc + PRESS_LAT);
        e = cyc + PRESS_LAT + 1;
        d = 1000 + int'(v[10:0]);
        repeat (HOLD) @(negedge clk);
        drive(which, 1'b1);
        repeat (HOLD) @(negedge clk);
    endtask

    always @(negedge clk) begin : mon
        res_t r;
        int   c;
        if (rst_n) begin
            if (non_bcd(digits) || non_bcd(dig2)) bcd_bad++;
            if (dut.u_deb.press) begin
                check("press expected", press_q.size() != 0, 1);
                if (press_q.size() != 0) begin
                    c = press_q.pop_front();
                    check("press cycle", cyc, c);
                end
            end
            if (go_led && !go_p) begin
                check("go expected", goq.size() != 0, 1);
                if (goq.size() != 0) begin
                    c = goq.pop_front();
                    check("go cycle", cyc, c);
                end
            end
            if (go2 && !go2_p) begin
                check("go2 expected", goq2.size() != 0, 1);
                if (goq2.size() != 0) begin
                    c = goq2.pop_front();
                    check("go2 cycle", cyc, c);
                end
            end
            if (result_valid && !rv_p) begin
                check("done expected", dq.size() != 0, 1);
                if (dq.size() != 0) begin
                    r = dq.pop_front();
                    check("done digits", digits, r.d);
                    check("done foul", foul, r.f);
                    check("done timeout", timeout, r.t);
                    check("done go_led", go_led, 0);
                end
            end
            if (rv2 && !rv2_p) begin
                check("done2 expected", dq2.size() != 0, 1);
                if (dq2.size() != 0) begin
                    r = dq2.pop_front();
                    check("done2 digits", dig2, r.d);
                    check("done2 foul", foul2, r.f);
                    check("done2 timeout", to2, r.t);
                    check("done2 go_led", go2, 0);
                end
            end
        end
        go_p  <= go_led;
        rv_p  <= result_valid;
        go2_p <= go2;
        rv2_p <= rv2;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded 100000 cycles");
        $fatal(1);
    end

    // timeout and same-cycle foul on the 1-cycle-per-ms instance
    initial begin : t_seq
        int e, d;
        wait (rst_done);
        arm(1, e, d);
        dq2.push_back('{16'h0000, 1'b1, 1'b0});
        press_at(1, e + d - 1);
        arm(1, e, d);
        goq2.push_back(e + d);
        dq2.push_back('{16'h9999, 1'b0, 1'b1});
        while (cyc < e + d + 10_005) @(negedge clk);
        check("dut2 digits held", dig2, 16'h9999);
        t_done = 1;
    end

    initial begin : main_seq
        int          e, d, g;
        logic [15:0] v;
        repeat (3) @(negedge clk);
        check("rst digits", digits, 16'h0000);
        check("rst go_led", go_led, 0);
        check("rst result_valid", result_valid, 0);
        check("rst foul", foul, 0);
        check("rst timeout", timeout, 0);
        check("rst state", dut.state, 2'd0);
        check("rst digits2", dig2, 16'h0000);
        rst_n = 1;
        rst_done = 1;

        // bounce for 20 cycles then hold: one press only
        wait_good(PRESS_LAT + 20, v);
        for (int i = 0; i < 10; i++) begin
            btn_n = ~btn_n;
            repeat (2) @(negedge clk);
        end
        btn_n = 0;
        press_q.push_back(cyc + PRESS_LAT);
        e = cyc + PRESS_LAT + 1;
        d = 1000 + int'(v[10:0]);
        g = e + d * MS;
        goq.push_back(g);
        repeat (30) @(negedge clk);
        check("arm state", dut.state, 2'd1);
        btn_n = 1;
        repeat (HOLD) @(negedge clk);

        dq.push_back('{16'h0123, 1'b0, 1'b0});
        press_at(0, g + 1234);
        check("done held digits", digits, 16'h0123);
        check("done result_valid", result_valid, 1);

        // early press in ARM
        arm(0, e, d);
        dq.push_back('{16'h0000, 1'b1, 1'b0});
        press_at(0, e + 200);

        for (int i = 0; i < 60000 && !t_done; i++) @(negedge clk);
        check("dut2 finished", t_done, 1);

        // reset in the middle of GO
        arm(0, e, d);
        g = e + d * MS;
        goq.push_back(g);
        while (cyc < g + 4565) @(negedge clk);
        check("mid digits", digits, 16'h0456);
        check("mid go_led", go_led, 1);
        rst_n = 0;
        @(negedge clk);
        check("mrst digits", digits, 16'h0000);
        check("mrst go_led", go_led, 0);
        check("mrst result_valid", result_valid, 0);
        check("mrst foul", foul, 0);
        check("mrst timeout", timeout, 0);
        check("mrst state", dut.state, 2'd0);
        rst_n = 1;

        // clean attempt after reset
        arm(0, e, d);
        check("rearm digits", digits, 16'h0000);
        check("rearm go_led", go_led, 0);
        check("rearm state", dut.state, 2'd1);
        g = e + d * MS;
        goq.push_back(g);
        dq.push_back('{16'h0005, 1'b0, 1'b0});
        press_at(0, g + 51);

        repeat (5) @(negedge clk);
        check("press_q drained", press_q.size(), 0);
        check("goq drained", goq.size(), 0);
        check("goq2 drained", goq2.size(), 0);
        check("dq drained", dq.size(), 0);
        check("dq2 drained", dq2.size(), 0);
        check("bcd nibbles", bcd_bad, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
